// File: rtl/if_id_latch.sv
// IF/ID pipeline register: captures fetched instruction and PC+4 on an icache
// hit, exposes pre-split MIPS fields, and applies stall, flush and HALT freezing.
module if_id_latch #(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned CNT_W       = 32,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  input  logic [WORD_W-1:0] npc_IF,
  input  logic              stall,
  input  logic              flush,
  output logic [WORD_W-1:0] instr_IF_ID,
  output logic [WORD_W-1:0] npc_IF_ID,
  output logic [5:0]        opcode_IF_ID,
  output logic [4:0]        rs_IF_ID,
  output logic [4:0]        rt_IF_ID,
  output logic [4:0]        rd_IF_ID,
  output logic [4:0]        shamt_IF_ID,
  output logic [5:0]        func_IF_ID,
  output logic [15:0]       imm16_IF_ID,
  output logic [25:0]       addr_IF_ID,
  output logic              valid_IF_ID,
  output logic              pc_en,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t state, state_next;
  logic   capture;

  assign capture = ihit & ~stall & ~flush & (state == RUN);

  // Flush must be able to steer the PC to the redirect target even when
  // stalled or halted. Gated by reset so every output reads zero while held.
  assign pc_en  = nRST & ((ihit & ~stall & (state == RUN)) | flush);
  assign halted = (state == HALTED);

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    if (flush)
      state_next = RUN;
    else if (capture && (imemload[31:26] == HALT_OPCODE))
      state_next = HALTED;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      // NOTE: non-blocking assignments for all clocked state so every register
      // samples pre-edge values regardless of statement order.
      state <= state_next;
    end
  end

  // Bubble is an all-zero word (sll r0,r0,0 = nop) with valid cleared.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      instr_IF_ID <= '0;
      npc_IF_ID   <= '0;
      valid_IF_ID <= 1'b0;
      fetch_count <= '0;
    end else if (flush) begin
      instr_IF_ID <= '0;
      npc_IF_ID   <= '0;
      valid_IF_ID <= 1'b0;
    end else if (capture) begin
      instr_IF_ID <= imemload;
      npc_IF_ID   <= npc_IF;
      valid_IF_ID <= 1'b1;
      fetch_count <= fetch_count + CNT_W'(1);
    end
  end

  assign opcode_IF_ID = instr_IF_ID[31:26];
  assign rs_IF_ID     = instr_IF_ID[25:21];
  assign rt_IF_ID     = instr_IF_ID[20:16];
  assign rd_IF_ID     = instr_IF_ID[15:11];
  assign shamt_IF_ID  = instr_IF_ID[10:6];
  assign func_IF_ID   = instr_IF_ID[5:0];
  assign imm16_IF_ID  = instr_IF_ID[15:0];
  assign addr_IF_ID   = instr_IF_ID[25:0];

endmodule

// File: tb/tb_if_id_latch.sv
// Directed self-checking bench for if_id_latch: capture, stall, flush, HALT,
// counter wrap on a narrow-counter instance, and asynchronous reset.
module tb_if_id_latch;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, stall, flush;
  logic [31:0] imemload, npc_IF;

  logic [31:0] instr, npc;
  logic [5:0]  opcode, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] addr;
  logic        valid, pc_en, halted;
  logic [31:0] count;

  logic [31:0] instr_n, npc_n;
  logic [5:0]  opcode_n, func_n;
  logic [4:0]  rs_n, rt_n, rd_n, shamt_n;
  logic [15:0] imm16_n;
  logic [25:0] addr_n;
  logic        valid_n, pc_en_n, halted_n;
  logic [3:0]  count_n;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  if_id_latch dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .npc_IF(npc_IF),
    .stall(stall), .flush(flush), .instr_IF_ID(instr), .npc_IF_ID(npc),
    .opcode_IF_ID(opcode), .rs_IF_ID(rs), .rt_IF_ID(rt), .rd_IF_ID(rd),
    .shamt_IF_ID(shamt), .func_IF_ID(func), .imm16_IF_ID(imm16),
    .addr_IF_ID(addr), .valid_IF_ID(valid), .pc_en(pc_en), .halted(halted),
    .fetch_count(count)
  );

  if_id_latch #(.CNT_W(4)) dut_narrow (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .npc_IF(npc_IF),
    .stall(stall), .flush(flush), .instr_IF_ID(instr_n), .npc_IF_ID(npc_n),
    .opcode_IF_ID(opcode_n), .rs_IF_ID(rs_n), .rt_IF_ID(rt_n), .rd_IF_ID(rd_n),
    .shamt_IF_ID(shamt_n), .func_IF_ID(func_n), .imm16_IF_ID(imm16_n),
    .addr_IF_ID(addr_n), .valid_IF_ID(valid_n), .pc_en(pc_en_n),
    .halted(halted_n), .fetch_count(count_n)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; ihit = 1'b0; stall = 1'b0; flush = 1'b0;
    imemload = '0; npc_IF = '0;
    repeat (2) tick();
    checks++;
    if ({instr, npc, valid, pc_en, halted, count} !== '0) begin
      $display("FAIL reset_outputs instr=%h npc=%h valid=%b pc_en=%b halted=%b count=%0d want all 0",
               instr, npc, valid, pc_en, halted, count);
      errors++;
    end
    checks++;
    if (count_n !== 4'd0) begin
      $display("FAIL reset_narrow_count got=%0d want=0", count_n); errors++;
    end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_capture();
    ihit = 1'b1; imemload = 32'h2001_0005; npc_IF = 32'd4;
    #1;
    checks++;
    if (pc_en !== 1'b1) begin $display("FAIL cap_pc_en got=%b want=1", pc_en); errors++; end
    tick();
    ihit = 1'b0;
    checks++;
    if (opcode !== 6'h08 || rs !== 5'd0 || rt !== 5'd1 || imm16 !== 16'h0005) begin
      $display("FAIL cap_fields opcode=%h rs=%0d rt=%0d imm16=%h want 08/0/1/0005",
               opcode, rs, rt, imm16);
      errors++;
    end
    checks++;
    if (npc !== 32'd4 || valid !== 1'b1 || count !== 32'd1) begin
      $display("FAIL cap_state npc=%0d valid=%b count=%0d want 4/1/1", npc, valid, count);
      errors++;
    end
  endtask

  task automatic test_stall();
    stall = 1'b1; ihit = 1'b1; imemload = 32'h0022_1820; npc_IF = 32'd8;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (pc_en !== 1'b0) begin $display("FAIL stall_pc_en cyc=%0d got=%b want=0", i, pc_en); errors++; end
      tick();
      checks++;
      if (instr !== 32'h2001_0005 || count !== 32'd1 || npc !== 32'd4) begin
        $display("FAIL stall_hold cyc=%0d instr=%h count=%0d npc=%0d want 20010005/1/4",
                 i, instr, count, npc);
        errors++;
      end
    end
    stall = 1'b0;
    tick();
    ihit = 1'b0;
    checks++;
    if (instr !== 32'h0022_1820 || rd !== 5'd3 || func !== 6'h20 || rt !== 5'd2 || count !== 32'd2) begin
      $display("FAIL stall_release instr=%h rd=%0d func=%h rt=%0d count=%0d want 00221820/3/20/2/2",
               instr, rd, func, rt, count);
      errors++;
    end
    tick();
    checks++;
    if (instr !== 32'h0022_1820 || valid !== 1'b1 || pc_en !== 1'b0) begin
      $display("FAIL idle_hold instr=%h valid=%b pc_en=%b want 00221820/1/0", instr, valid, pc_en);
      errors++;
    end
  endtask

  task automatic test_flush();
    flush = 1'b1; stall = 1'b1; ihit = 1'b1; imemload = 32'h8C41_0004; npc_IF = 32'd12;
    #1;
    checks++;
    if (pc_en !== 1'b1) begin $display("FAIL flush_pc_en got=%b want=1", pc_en); errors++; end
    tick();
    flush = 1'b0; stall = 1'b0; ihit = 1'b0;
    checks++;
    if (instr !== 32'h0 || npc !== 32'h0 || valid !== 1'b0 || count !== 32'd2) begin
      $display("FAIL flush_bubble instr=%h npc=%h valid=%b count=%0d want 0/0/0/2",
               instr, npc, valid, count);
      errors++;
    end
  endtask

  task automatic test_halt();
    ihit = 1'b1; imemload = 32'hFC00_0000; npc_IF = 32'h10;
    tick();
    checks++;
    if (halted !== 1'b1 || instr !== 32'hFC00_0000 || opcode !== 6'h3F || count !== 32'd3) begin
      $display("FAIL halt_enter halted=%b instr=%h opcode=%h count=%0d want 1/FC000000/3F/3",
               halted, instr, opcode, count);
      errors++;
    end
    imemload = 32'h2002_0007; npc_IF = 32'h14;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (pc_en !== 1'b0) begin $display("FAIL halt_pc_en cyc=%0d got=%b want=0", i, pc_en); errors++; end
      tick();
      checks++;
      if (instr !== 32'hFC00_0000 || count !== 32'd3 || halted !== 1'b1) begin
        $display("FAIL halt_hold cyc=%0d instr=%h count=%0d halted=%b want FC000000/3/1",
                 i, instr, count, halted);
        errors++;
      end
    end
    flush = 1'b1;
    #1;
    checks++;
    if (pc_en !== 1'b1) begin $display("FAIL halt_flush_pc_en got=%b want=1", pc_en); errors++; end
    tick();
    flush = 1'b0;
    checks++;
    if (halted !== 1'b0 || instr !== 32'h0 || valid !== 1'b0 || count !== 32'd3) begin
      $display("FAIL halt_flush halted=%b instr=%h valid=%b count=%0d want 0/0/0/3",
               halted, instr, valid, count);
      errors++;
    end
    tick();
    ihit = 1'b0;
    checks++;
    if (instr !== 32'h2002_0007 || npc !== 32'h14 || valid !== 1'b1 || count !== 32'd4) begin
      $display("FAIL halt_resume instr=%h npc=%h valid=%b count=%0d want 20020007/14/1/4",
               instr, npc, valid, count);
      errors++;
    end
  endtask

  task automatic test_async_reset();
    ihit = 1'b1; imemload = 32'hFC00_0000; npc_IF = 32'h18;
    tick();
    ihit = 1'b0;
    checks++;
    if (halted !== 1'b1) begin $display("FAIL areset_pre_halt got=%b want=1", halted); errors++; end
    #2;
    nRST = 1'b0;
    #1;
    checks++;
    if ({instr, npc, valid, pc_en, halted, count} !== '0 || count_n !== 4'd0) begin
      $display("FAIL areset_midcycle instr=%h npc=%h valid=%b pc_en=%b halted=%b count=%0d cn=%0d want all 0",
               instr, npc, valid, pc_en, halted, count, count_n);
      errors++;
    end
    @(negedge CLK);
    nRST = 1'b1;
    ihit = 1'b1; imemload = 32'h3C01_1234; npc_IF = 32'h20;
    tick();
    ihit = 1'b0;
    checks++;
    if (instr !== 32'h3C01_1234 || imm16 !== 16'h1234 || halted !== 1'b0 || count !== 32'd1 || valid !== 1'b1) begin
      $display("FAIL areset_recover instr=%h imm16=%h halted=%b count=%0d valid=%b want 3C011234/1234/0/1/1",
               instr, imm16, halted, count, valid);
      errors++;
    end
  endtask

  task automatic test_wrap();
    ihit = 1'b1;
    for (int i = 0; i < 14; i++) begin
      imemload = 32'h2000_0000 + 32'(i); npc_IF = 32'h24 + 32'(4 * i);
      tick();
    end
    checks++;
    if (count_n !== 4'hF || count !== 32'd15) begin
      $display("FAIL wrap_pre narrow=%0d wide=%0d want 15/15", count_n, count); errors++;
    end
    imemload = 32'h0800_0040;
    tick();
    ihit = 1'b0;
    checks++;
    if (count_n !== 4'h0 || count !== 32'd16 || addr !== 26'h40) begin
      $display("FAIL wrap_post narrow=%0d wide=%0d addr=%h want 0/16/40", count_n, count, addr);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_stall();
    test_flush();
    test_halt();
    test_async_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
